// File: rtl/sipo_rr_sched.sv
// rtl/sipo_rr_sched.sv - round-robin scheduler sharing one SIPO deserializer among NUM_REQ serial sources
// Grants one lane, assembles WORD_BW bits from it, holds the word on a valid/ready port, then re-arbitrates.
module sipo_rr_sched #(
   parameter int NUM_REQ    = 4,
   parameter int WORD_BW    = 8,
   parameter int SHIFT_LEFT = 1
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic [NUM_REQ-1:0]         req_i,
   input  logic [NUM_REQ-1:0]         serial_data_i,
   input  logic [NUM_REQ-1:0]         bit_valid_i,
   output logic [NUM_REQ-1:0]         gnt_o,
   output logic [WORD_BW-1:0]         word_o,
   output logic [$clog2(NUM_REQ)-1:0] src_id_o,
   output logic                       word_valid_o,
   input  logic                       word_ready_i,
   output logic                       abort_o
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(WORD_BW) + 1;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t             r_state, w_state_n;
   logic [NUM_REQ-1:0] r_gnt, w_gnt_n;
   logic [WORD_BW-1:0] r_word, w_word_n, w_shifted;
   logic [ID_W-1:0]    r_src_id, w_src_id_n;
   logic [ID_W-1:0]    r_last_id, w_last_id_n;
   logic [ID_W-1:0]    w_win;
   logic [ID_W:0]      w_sum;
   logic [CNT_W-1:0]   r_bit_cnt, w_bit_cnt_n;
   logic               r_valid, w_valid_n;
   logic               r_abort, w_abort_n;
   logic               w_found;
   logic               w_bit, w_bit_valid, w_req_g;

   // Only the granted lane is ever observed while shifting.
   assign w_bit       = serial_data_i[r_src_id];
   assign w_bit_valid = bit_valid_i[r_src_id];
   assign w_req_g     = req_i[r_src_id];

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_state   <= IDLE;
         r_gnt     <= '0;
         r_word    <= '0;
         r_src_id  <= '0;
         r_last_id <= ID_W'(NUM_REQ - 1);
         r_bit_cnt <= '0;
         r_valid   <= 1'b0;
         r_abort   <= 1'b0;
      end else begin
         r_state   <= w_state_n;
         r_gnt     <= w_gnt_n;
         r_word    <= w_word_n;
         r_src_id  <= w_src_id_n;
         r_last_id <= w_last_id_n;
         r_bit_cnt <= w_bit_cnt_n;
         r_valid   <= w_valid_n;
         r_abort   <= w_abort_n;
      end
   end

   always_comb begin
      w_state_n   = r_state;
      w_gnt_n     = r_gnt;
      w_word_n    = r_word;
      w_src_id_n  = r_src_id;
      w_last_id_n = r_last_id;
      w_bit_cnt_n = r_bit_cnt;
      w_valid_n   = r_valid;
      w_abort_n   = 1'b0;
      w_found     = 1'b0;
      w_win       = r_last_id;
      w_sum       = '0;
      w_shifted   = r_word;

      // Scan starting one past the previous winner so every requester gets a turn.
      for (int i = 1; i <= NUM_REQ; i++) begin
         w_sum = {1'b0, r_last_id} + (ID_W+1)'(i);
         if (w_sum >= (ID_W+1)'(NUM_REQ)) w_sum = w_sum - (ID_W+1)'(NUM_REQ);
         if (!w_found && req_i[w_sum[ID_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[ID_W-1:0];
         end
      end

      if (SHIFT_LEFT != 0) w_shifted = {r_word[WORD_BW-2:0], w_bit};
      else                 w_shifted = {w_bit, r_word[WORD_BW-1:1]};

      case (r_state)
         IDLE: begin
            w_gnt_n = '0;
            if (w_found) begin
               w_gnt_n[w_win] = 1'b1;
               w_src_id_n     = w_win;
               w_last_id_n    = w_win;
               w_bit_cnt_n    = '0;
               w_state_n      = SHIFT;
            end
         end
         SHIFT: begin
            // A request drop wins over a bit arriving in the same cycle.
            if (!w_req_g) begin
               w_abort_n   = 1'b1;
               w_gnt_n     = '0;
               w_bit_cnt_n = '0;
               w_state_n   = IDLE;
            end else if (w_bit_valid) begin
               w_word_n    = w_shifted;
               w_bit_cnt_n = r_bit_cnt + CNT_W'(1);
               if (r_bit_cnt == CNT_W'(WORD_BW - 1)) begin
                  w_valid_n = 1'b1;
                  w_gnt_n   = '0;
                  w_state_n = HOLD;
               end
            end
         end
         HOLD: begin
            if (r_valid && word_ready_i) begin
               w_valid_n   = 1'b0;
               w_bit_cnt_n = '0;
               w_state_n   = IDLE;
            end
         end
         default: begin
            w_state_n = IDLE;
            w_gnt_n   = '0;
            w_valid_n = 1'b0;
         end
      endcase
   end

   assign gnt_o        = r_gnt;
   assign word_o       = r_word;
   assign src_id_o     = r_src_id;
   assign word_valid_o = r_valid;
   assign abort_o      = r_abort;

endmodule

// File: tb/tb_sipo_rr_sched.sv
// tb/tb_sipo_rr_sched.sv - directed self-checking bench for sipo_rr_sched
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_sipo_rr_sched;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic [3:0] req_i = '0;
   logic [3:0] serial_data_i = '0;
   logic [3:0] bit_valid_i = '0;
   logic [3:0] gnt_o;
   logic [7:0] word_o;
   logic [1:0] src_id_o;
   logic       word_valid_o;
   logic       word_ready_i = 1'b0;
   logic       abort_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] words [4] = '{8'h11, 8'hA7, 8'h3C, 8'hE9};

   sipo_rr_sched #(.NUM_REQ(4), .WORD_BW(8), .SHIFT_LEFT(1)) dut (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .req_i        (req_i),
      .serial_data_i(serial_data_i),
      .bit_valid_i  (bit_valid_i),
      .gnt_o        (gnt_o),
      .word_o       (word_o),
      .src_id_o     (src_id_o),
      .word_valid_o (word_valid_o),
      .word_ready_i (word_ready_i),
      .abort_o      (abort_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Non-granted lanes carry the inverted bit so any leakage corrupts the word.
   task automatic drive(input int lane, input bit v, input bit d, input bit noise);
      logic [3:0] bv;
      logic [3:0] sd;
      sd = d ? 4'b0000 : 4'b1111;
      sd[lane] = d;
      bv = noise ? 4'($urandom_range(0, 15)) : 4'b0000;
      bv[lane] = v;
      serial_data_i = sd;
      bit_valid_i   = bv;
   endtask

   task automatic send_bits(input int lane, input logic [7:0] data, input int hi, input int lo,
                            input bit gaps, input bit noise);
      for (int b = hi; b >= lo; b--) begin
         if (gaps) begin
            drive(lane, 1'b0, ~data[b], noise);
            step();
         end
         drive(lane, 1'b1, data[b], noise);
         step();
      end
      bit_valid_i   = '0;
      serial_data_i = '0;
   endtask

   task automatic handshake(input string tag);
      req_i        = '0;
      word_ready_i = 1'b1;
      step();
      word_ready_i = 1'b0;
      check_val({tag, "_valid_drop"}, 32'(word_valid_o), 32'd0);
   endtask

   initial begin
      // Reset state
      step();
      check_val("rst_gnt", 32'(gnt_o), 32'h0);
      check_val("rst_word", 32'(word_o), 32'h0);
      check_val("rst_src", 32'(src_id_o), 32'h0);
      check_val("rst_valid", 32'(word_valid_o), 32'h0);
      check_val("rst_abort", 32'(abort_o), 32'h0);
      reset_i = 1'b0;
      step();

      // 1) Basic word from lane 0
      req_i = 4'b0001;
      step();
      check_val("t1_gnt", 32'(gnt_o), 32'h1);
      check_val("t1_src", 32'(src_id_o), 32'h0);
      send_bits(0, 8'hB2, 7, 1, 1'b0, 1'b0);
      check_val("t1_valid_after7", 32'(word_valid_o), 32'h0);
      check_val("t1_gnt_after7", 32'(gnt_o), 32'h1);
      send_bits(0, 8'hB2, 0, 0, 1'b0, 1'b0);
      check_val("t1_valid", 32'(word_valid_o), 32'h1);
      check_val("t1_word", 32'(word_o), 32'hB2);
      check_val("t1_src_word", 32'(src_id_o), 32'h0);
      check_val("t1_gnt_hold", 32'(gnt_o), 32'h0);
      handshake("t1");

      // 2) Gapped bits from lane 3, consumer stalls 5 cycles
      req_i = 4'b1000;
      step();
      check_val("t2_gnt", 32'(gnt_o), 32'h8);
      send_bits(3, 8'h5C, 7, 0, 1'b1, 1'b0);
      for (int k = 0; k < 5; k++) begin
         check_val("t2_hold_valid", 32'(word_valid_o), 32'h1);
         check_val("t2_hold_word", 32'(word_o), 32'h5C);
         check_val("t2_hold_src", 32'(src_id_o), 32'h3);
         check_val("t2_hold_gnt", 32'(gnt_o), 32'h0);
         step();
      end
      handshake("t2");

      // 3) All lanes requesting: order 0,1,2,3 then 0
      req_i = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         req_i = 4'b1111;
         step();
         check_val("t3_gnt", 32'(gnt_o), 32'(1 << k));
         send_bits(k, words[k], 7, 0, 1'b0, 1'b0);
         check_val("t3_valid", 32'(word_valid_o), 32'h1);
         check_val("t3_word", 32'(word_o), 32'(words[k]));
         check_val("t3_src", 32'(src_id_o), 32'(k));
         word_ready_i = 1'b1;
         step();
         word_ready_i = 1'b0;
         check_val("t3_valid_drop", 32'(word_valid_o), 32'h0);
      end
      step();
      check_val("t3_wrap_gnt", 32'(gnt_o), 32'h1);
      req_i = 4'b0000;
      step();
      check_val("t3_abort", 32'(abort_o), 32'h1);
      step();
      check_val("t3_abort_end", 32'(abort_o), 32'h0);

      // 4) Abort lane 2 after 3 bits; next grant goes past lane 2
      req_i = 4'b1100;
      step();
      check_val("t4_gnt", 32'(gnt_o), 32'h4);
      send_bits(2, 8'hFF, 7, 5, 1'b0, 1'b0);
      req_i = 4'b1011;
      drive(2, 1'b1, 1'b1, 1'b0);
      step();
      bit_valid_i = '0;
      check_val("t4_abort", 32'(abort_o), 32'h1);
      check_val("t4_abort_gnt", 32'(gnt_o), 32'h0);
      check_val("t4_abort_valid", 32'(word_valid_o), 32'h0);
      step();
      check_val("t4_abort_pulse", 32'(abort_o), 32'h0);
      check_val("t4_next_gnt", 32'(gnt_o), 32'h8);
      check_val("t4_next_src", 32'(src_id_o), 32'h3);
      send_bits(3, 8'h96, 7, 1, 1'b0, 1'b0);
      check_val("t4_valid_after7", 32'(word_valid_o), 32'h0);
      send_bits(3, 8'h96, 0, 0, 1'b0, 1'b0);
      check_val("t4_valid", 32'(word_valid_o), 32'h1);
      check_val("t4_word", 32'(word_o), 32'h96);
      handshake("t4");

      // 5) Asynchronous reset mid-SHIFT
      req_i = 4'b0010;
      step();
      check_val("t5_gnt", 32'(gnt_o), 32'h2);
      send_bits(1, 8'hFF, 7, 5, 1'b0, 1'b0);
      #3;
      reset_i = 1'b1;
      #1;
      check_val("t5_rst_gnt", 32'(gnt_o), 32'h0);
      check_val("t5_rst_word", 32'(word_o), 32'h0);
      check_val("t5_rst_src", 32'(src_id_o), 32'h0);
      check_val("t5_rst_valid", 32'(word_valid_o), 32'h0);
      check_val("t5_rst_abort", 32'(abort_o), 32'h0);
      step();
      reset_i = 1'b0;
      req_i = 4'b0100;
      step();
      check_val("t5_gnt_after", 32'(gnt_o), 32'h4);
      check_val("t5_src_after", 32'(src_id_o), 32'h2);
      send_bits(2, 8'h3A, 7, 1, 1'b0, 1'b0);
      check_val("t5_valid_after7", 32'(word_valid_o), 32'h0);
      send_bits(2, 8'h3A, 0, 0, 1'b0, 1'b0);
      check_val("t5_valid", 32'(word_valid_o), 32'h1);
      check_val("t5_word", 32'(word_o), 32'h3A);
      handshake("t5");

      // 6) Noise on ungranted lanes during lane 1's word
      req_i = 4'b0010;
      step();
      check_val("t6_gnt", 32'(gnt_o), 32'h2);
      send_bits(1, 8'hC5, 7, 0, 1'b1, 1'b1);
      check_val("t6_valid", 32'(word_valid_o), 32'h1);
      check_val("t6_word", 32'(word_o), 32'hC5);
      check_val("t6_src", 32'(src_id_o), 32'h1);
      handshake("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
